// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared widths and stage-count helper for the pipelined ripple adder.
package pipelined_ripple_adder_pkg;

    localparam int ADD_WIDTH = 16;
    localparam int ADD_SEG_W = 4;

    function automatic int calc_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/pipelined_ripple_adder_seg.sv
// One SEG_W-bit combinational ripple segment built from single-bit full adders.
// The carry into the top bit is exposed so the last segment can flag signed overflow.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module seg_ripple_adder #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic [SEG_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co       = c[SEG_W];
    assign c_msb_in = c[SEG_W-1];
endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG_W-bit segment per stage, with
// operand skew and sum deskew carried alongside, and a global stall on back-pressure.
module pipelined_ripple_adder
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int SEG_W = ADD_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSEG = calc_nseg(WIDTH, SEG_W);

    if (WIDTH < SEG_W || (WIDTH % SEG_W) != 0) begin : g_param_check
        $fatal(1, "pipelined_ripple_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    logic             v_q  [NSEG];
    logic             v_d  [NSEG];
    logic [WIDTH-1:0] a_q  [NSEG];
    logic [WIDTH-1:0] a_d  [NSEG];
    logic [WIDTH-1:0] b_q  [NSEG];
    logic [WIDTH-1:0] b_d  [NSEG];
    logic [WIDTH-1:0] s_q  [NSEG];
    logic [WIDTH-1:0] s_d  [NSEG];
    logic             c_q  [NSEG];
    logic             c_d  [NSEG];
    logic             cmsb [NSEG];
    logic             ovf_q;

    // The whole pipe moves together; it only freezes when the output slot is full and unread.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = b ^ {WIDTH{sub}};
    assign c_eff    = sub | cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG_W{1'b1}}) << (k * SEG_W);

        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic [SEG_W-1:0] seg_s;

        if (k == 0) begin : g_head
            assign v_d[k] = in_valid;
            assign a_d[k] = a;
            assign b_d[k] = b_eff;
            assign s_src  = '0;
            assign c_src  = c_eff;
        end else begin : g_body
            assign v_d[k] = v_q[k-1];
            assign a_d[k] = a_q[k-1];
            assign b_d[k] = b_q[k-1];
            assign s_src  = s_q[k-1];
            assign c_src  = c_q[k-1];
        end

        seg_ripple_adder #(.SEG_W(SEG_W)) u_seg (
            .a        (a_d[k][k*SEG_W +: SEG_W]),
            .b        (b_d[k][k*SEG_W +: SEG_W]),
            .ci       (c_src),
            .s        (seg_s),
            .co       (c_d[k]),
            .c_msb_in (cmsb[k])
        );

        // Lower slices pass through unchanged; this stage fills in its own slice.
        assign s_d[k] = (s_src & ~SEG_MASK) | (WIDTH'(seg_s) << (k * SEG_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NSEG; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            ovf_q <= cmsb[NSEG-1] ^ c_d[NSEG-1];
        end
    end

    assign out_valid = v_q[NSEG-1];
    assign sum       = s_q[NSEG-1];
    assign cout      = c_q[NSEG-1];
    assign ovf       = ovf_q;
endmodule
